ahb_manager_arbiter: RTL

//  Shares one AHB-Lite manager port between NumRequesters local requesters.

---
 rtl/ahb_arb_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 58 +++++
 rtl/ahb_manager_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/ahb_arb_pkg.sv
// Shared AHB-Lite encodings used by the manager-port arbiter and its bench.
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'b000,
    HSIZE_HALF  = 3'b001,
    HSIZE_WORD  = 3'b010,
    HSIZE_DWORD = 3'b011
  } hsize_e;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a rotating pointer that
// moves past the winner whenever the grant is consumed.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);
  localparam int IdW = $clog2(N);

  logic [IdW-1:0] ptr_q;
  logic [IdW-1:0] ptr_d;
  logic           found_s;

  // First pending request at or after the pointer wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found_s   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found_s && req[(int'(ptr_q) + i) % N]) begin
        found_s   = 1'b1;
        grant_idx = IdW'((int'(ptr_q) + i) % N);
        grant[(int'(ptr_q) + i) % N] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer next-state
  always_comb begin
    ptr_d = ptr_q;
    if (advance && found_s) begin
      if (int'(grant_idx) == N - 1) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx + IdW'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ahb_manager_arbiter.sv
// Shares one AHB-Lite manager port between several requesters: round-robin
// grant into an address stage, pipelined single-beat data stage, routed responses.
module ahb_manager_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NumRequesters = 4,
  parameter int AddressWidth  = 32,
  parameter int DataWidth     = 32
) (
  input  logic                               HCLK,
  input  logic                               HRESET,
  input  logic [NumRequesters-1:0]           req_valid,
  input  logic [NumRequesters-1:0]           req_write,
  input  logic [NumRequesters*AddressWidth-1:0] req_addr,
  input  logic [NumRequesters*DataWidth-1:0] req_wdata,
  input  logic [NumRequesters*3-1:0]         req_size,
  output logic [NumRequesters-1:0]           req_ready,
  output logic [NumRequesters-1:0]           rsp_valid,
  output logic [DataWidth-1:0]               rsp_rdata,
  output logic                               rsp_error,
  output logic [AddressWidth-1:0]            HADDR,
  output logic                               HWRITE,
  output logic [2:0]                         HSIZE,
  output logic [1:0]                         HTRANS,
  output logic [2:0]                         HBURST,
  output logic [DataWidth-1:0]               HWDATA,
  input  logic [DataWidth-1:0]               HRDATA,
  input  logic                               HREADY,
  input  logic                               HRESP
);
  localparam int IdW = $clog2(NumRequesters);

  logic                     a_valid_q, a_valid_d, a_write_q, a_write_d, a_susp_q, a_susp_d;
  logic [IdW-1:0]           a_id_q, a_id_d, d_id_q, d_id_d;
  logic [AddressWidth-1:0]  a_addr_q, a_addr_d;
  logic [2:0]               a_size_q, a_size_d;
  logic [DataWidth-1:0]     a_wdata_q, a_wdata_d, hwdata_q, hwdata_d;
  logic                     d_valid_q, d_valid_d, d_write_q, d_write_d;
  htrans_e                  htrans_q, htrans_d;
  logic [NumRequesters-1:0] rsp_valid_q, rsp_valid_d;
  logic [DataWidth-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic                     rsp_error_q, rsp_error_d;

  logic                     a_adv_s, a_load_s, d_done_s;
  logic [NumRequesters-1:0] grant_s;
  logic [IdW-1:0]           grant_idx_s;

  assign a_adv_s  = HREADY && (htrans_q == HTRANS_NONSEQ);
  assign a_load_s = (!a_valid_q || a_adv_s) && !a_susp_q;
  assign d_done_s = HREADY && d_valid_q;

  rr_arbiter #(.N(NumRequesters)) u_rr (
    .clk       (HCLK),
    .rst       (HRESET),
    .req       (req_valid),
    .advance   (a_load_s),
    .grant     (grant_s),
    .grant_idx (grant_idx_s)
  );

  assign req_ready = (a_load_s && !HRESET) ? grant_s : '0;

  // Pipeline next-state: A-stage load/hold, A->D advance, error suspend, response
  always_comb begin
    a_valid_d   = a_valid_q;
    a_id_d      = a_id_q;
    a_addr_d    = a_addr_q;
    a_write_d   = a_write_q;
    a_size_d    = a_size_q;
    a_wdata_d   = a_wdata_q;
    d_valid_d   = d_valid_q;
    d_id_d      = d_id_q;
    d_write_d   = d_write_q;
    hwdata_d    = hwdata_q;
    a_susp_d    = a_susp_q;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_error_d = 1'b0;

    if (a_load_s) begin
      a_valid_d = |req_valid;
      if (|req_valid) begin
        a_id_d    = grant_idx_s;
        a_addr_d  = req_addr[int'(grant_idx_s)*AddressWidth +: AddressWidth];
        a_write_d = req_write[grant_idx_s];
        a_size_d  = req_size[int'(grant_idx_s)*3 +: 3];
        a_wdata_d = req_wdata[int'(grant_idx_s)*DataWidth +: DataWidth];
      end else begin
        a_id_d = a_id_q;
      end
    end else begin
      a_valid_d = a_valid_q;
    end

    // The D-stage refills from the A-stage even while it completes
    if (a_adv_s) begin
      d_valid_d = 1'b1;
      d_id_d    = a_id_q;
      d_write_d = a_write_q;
      hwdata_d  = a_wdata_q;
    end else if (d_done_s) begin
      d_valid_d = 1'b0;
    end else begin
      d_valid_d = d_valid_q;
    end

    if (a_susp_q) begin
      a_susp_d = !HREADY;
    end else begin
      a_susp_d = d_valid_q && (HRESP == HRESP_ERROR) && !HREADY;
    end

    if (d_done_s) begin
      rsp_valid_d = {{(NumRequesters-1){1'b0}}, 1'b1} << d_id_q;
      rsp_rdata_d = d_write_q ? '0 : HRDATA;
      rsp_error_d = HRESP;
    end else begin
      rsp_valid_d = '0;
    end

    htrans_d = (a_valid_d && !a_susp_d) ? HTRANS_NONSEQ : HTRANS_IDLE;
  end

  // State and output registers
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      a_valid_q   <= 1'b0;
      a_id_q      <= '0;
      a_addr_q    <= '0;
      a_write_q   <= 1'b0;
      a_size_q    <= 3'b000;
      a_wdata_q   <= '0;
      a_susp_q    <= 1'b0;
      d_valid_q   <= 1'b0;
      d_id_q      <= '0;
      d_write_q   <= 1'b0;
      hwdata_q    <= '0;
      htrans_q    <= HTRANS_IDLE;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      a_valid_q   <= a_valid_d;
      a_id_q      <= a_id_d;
      a_addr_q    <= a_addr_d;
      a_write_q   <= a_write_d;
      a_size_q    <= a_size_d;
      a_wdata_q   <= a_wdata_d;
      a_susp_q    <= a_susp_d;
      d_valid_q   <= d_valid_d;
      d_id_q      <= d_id_d;
      d_write_q   <= d_write_d;
      hwdata_q    <= hwdata_d;
      htrans_q    <= htrans_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign HADDR     = a_addr_q;
  assign HWRITE    = a_write_q;
  assign HSIZE     = a_size_q;
  assign HTRANS    = htrans_q;
  assign HBURST    = HBURST_SINGLE;
  assign HWDATA    = hwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule
